// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM and ALU decoder for a multicycle MIPS datapath
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state, next;
  logic pcwrite, branch, ir_w, mem_w, reg_w;
  logic [1:0] aluop;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:   next = DECODE;
      DECODE:  next = (op == OP_LW || op == OP_SW) ? MEMADR :
                      op == OP_R    ? RTYPEEX :
                      op == OP_BEQ  ? BEQEX :
                      op == OP_ADDI ? ADDIEX :
                      op == OP_J    ? JEX : FETCH;
      MEMADR:  next = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   next = MEMWB;
      RTYPEEX: next = RTYPEWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    iord = 1'b0;
    mem_w = 1'b0;
    ir_w = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    reg_w = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    pcwrite = 1'b0;
    branch = 1'b0;
    aluop = 2'b00;
    case (state)
      FETCH:   begin ir_w = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
      DECODE:  alusrcb = 2'b11;
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; reg_w = 1'b1; end
      MEMWR:   begin iord = 1'b1; mem_w = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin regdst = 1'b1; reg_w = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:  reg_w = 1'b1;
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
  end
  // write enables are held off for the whole time reset is asserted
  assign irwrite  = ir_w & reset_n;
  assign memwrite = mem_w & reset_n;
  assign regwrite = reg_w & reset_n;
  assign pcen     = (pcwrite | (branch & zero)) & reset_n;
  assign alucontrol = aluop == 2'b01 ? 3'b110 :
                      aluop != 2'b10 ? 3'b010 :
                      funct == 6'b100010 ? 3'b110 :
                      funct == 6'b100100 ? 3'b000 :
                      funct == 6'b100101 ? 3'b001 :
                      funct == 6'b101010 ? 3'b111 : 3'b010;
  assign state_dbg = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: random instruction stream checked against a per-instruction control table model
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;
  int checks = 0, errors = 0;
  int seq[$];
  logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
  logic [5:0] functs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  wire [14:0] ctrl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol};
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (state %0d op %b funct %b zero %b)", tag, got, exp, state_dbg, op, funct, zero);
    end
  endtask
  function automatic void build_seq(input logic [5:0] o);
    seq.delete();
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1};
    endcase
  endfunction
  function automatic logic [2:0] alu_of(input logic [1:0] aop, input logic [5:0] f);
    if (aop == 2'b01) return 3'b110;
    if (aop != 2'b10) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  function automatic logic [14:0] exp_ctrl(input int s, input logic [5:0] f, input logic z, input bit rst);
    logic io = 0, mw = 0, iw = 0, rd = 0, mr = 0, rw = 0, sa = 0, pw = 0, br = 0;
    logic [1:0] sb = 0, ps = 0, aop = 0;
    case (s)
      0:  begin iw = 1; pw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin mr = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    if (rst) begin iw = 0; mw = 0; rw = 0; pw = 0; br = 0; end
    return {io, mw, iw, rd, mr, rw, sa, sb, ps, pw | (br & z), alu_of(aop, f)};
  endfunction
  task automatic do_reset_pulse();
    reset_n = 1'b0;
    #1;
    check("rst_state", {12'd0, state_dbg}, 16'd0);
    check("rst_ctrl", {1'b0, ctrl}, {1'b0, exp_ctrl(0, funct, zero, 1'b1)});
    @(posedge clk);
    #2;
    check("rst_hold", {12'd0, state_dbg}, 16'd0);
    reset_n = 1'b1;
  endtask
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at);
    build_seq(o);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin op = o; funct = f; end
      zero = 1'($urandom);
      #1;
      check("state", {12'd0, state_dbg}, 16'(seq[i]));
      check("ctrl", {1'b0, ctrl}, {1'b0, exp_ctrl(seq[i], funct, zero, 1'b0)});
      if (i == abort_at) begin
        do_reset_pulse();
        return;
      end
    end
  endtask
  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      zero = 1'($urandom);
      check("init_state", {12'd0, state_dbg}, 16'd0);
      check("init_ctrl", {1'b0, ctrl}, {1'b0, exp_ctrl(0, funct, zero, 1'b1)});
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    run_instr(6'b100011, 6'd0, -1);
    for (int i = 0; i < 6; i++) run_instr(6'b000000, functs[i], -1);
    run_instr(6'b100011, 6'd0, 3);
    run_instr(6'b101011, 6'd0, -1);
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [5:0] o, f;
      k = $urandom_range(0, 6);
      o = ops[k];
      if (k == 6) begin
        o = 6'($urandom);
        if (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 || o == 6'b001000 || o == 6'b000010) o = 6'b111111;
      end
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      build_seq(o);
      run_instr(o, f, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1);
    end
    @(negedge clk);
    #1;
    check("final_state", {12'd0, state_dbg}, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
